fifo_ctrl: RTL

Pointer/flag controller for a circular FIFO built around the team's synchronous-write, asynchronous-read register file. It drives the file's write enable, write address and read address directly. It turns push/pop requests into safe, gated accesses, tracks occupancy, and raises full/empty, threshold and error flags. Read data is taken combinationally from the register file at r_addr, so the head entry is always visible while empty=0.

---
 rtl/fifo_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for a circular FIFO wrapped around a
// register file with synchronous write and asynchronous read.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = 3,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_L    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_L    = AE_LEVEL[ADDR_WIDTH:0];
  localparam logic                AF_RST  = (AF_L == '0);

  logic [ADDR_WIDTH-1:0] w_addr_reg, w_addr_next;
  logic [ADDR_WIDTH-1:0] r_addr_reg, r_addr_next;
  logic [ADDR_WIDTH:0]   level_reg, level_next;
  logic                  full_reg, empty_reg, af_reg, ae_reg;
  logic                  ovf_reg, ovf_next, unf_reg, unf_next;
  logic                  push_ok, pop_ok;

  // A push into a full FIFO is still safe when the head is popped the same cycle.
  assign push_ok = wr & (~full_reg | rd);
  assign pop_ok  = rd & ~empty_reg;
  assign wr_en   = push_ok & ~clr & reset_n;

  always_comb begin
    w_addr_next = w_addr_reg;
    r_addr_next = r_addr_reg;
    level_next  = level_reg;
    ovf_next    = ovf_reg;
    unf_next    = unf_reg;
    if (clr) begin
      w_addr_next = '0;
      r_addr_next = '0;
      level_next  = '0;
      ovf_next    = 1'b0;
      unf_next    = 1'b0;
    end else begin
      if (push_ok) w_addr_next = w_addr_reg + ADDR_WIDTH'(1);
      if (pop_ok)  r_addr_next = r_addr_reg + ADDR_WIDTH'(1);
      level_next = level_reg + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop_ok);
      if (wr & ~push_ok) ovf_next = 1'b1;
      // A pop on empty alongside a push is simply a write, not an error.
      if (rd & ~wr & empty_reg) unf_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_addr_reg <= '0;
      r_addr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      af_reg     <= AF_RST;
      ae_reg     <= 1'b1;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else begin
      w_addr_reg <= w_addr_next;
      r_addr_reg <= r_addr_next;
      level_reg  <= level_next;
      full_reg   <= (level_next == DEPTH_L);
      empty_reg  <= (level_next == '0);
      af_reg     <= (level_next >= AF_L);
      ae_reg     <= (level_next <= AE_L);
      ovf_reg    <= ovf_next;
      unf_reg    <= unf_next;
    end
  end

  assign w_addr       = w_addr_reg;
  assign r_addr       = r_addr_reg;
  assign level        = level_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = af_reg;
  assign almost_empty = ae_reg;
  assign overflow     = ovf_reg;
  assign underflow    = unf_reg;

endmodule
